// File: rtl/latch_sr_sync_pkg.sv
// rtl/latch_sr_sync_pkg.sv - shared constants for the magnetron enable set/reset element
package latch_sr_sync_pkg;

  // Stored-state encodings: Q_ON means the magnetron is enabled
  localparam logic Q_OFF = 1'b0;
  localparam logic Q_ON  = 1'b1;

  // Default depth of the input synchronisers; legal depths are 0..SYNC_STAGES_MAX
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int SYNC_STAGES_MAX     = 4;

endpackage

// File: rtl/latch_sr_sync_sync_ff_chain.sv
// rtl/latch_sr_sync_sync_ff_chain.sv - N-stage single-bit synchroniser with synchronous reset
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  generate
    if (STAGES == 0) begin : g_bypass
      // Input is already synchronous to clk; pass it straight through
      assign q = d;
    end else if (STAGES == 1) begin : g_single
      logic ff;

      // Single capture flop, cleared on reset
      always_ff @(posedge clk) begin
        if (rst) ff <= 1'b0;
        else     ff <= d;
      end

      assign q = ff;
    end else begin : g_chain
      logic [STAGES-1:0] ff;

      // Shift the input through the chain; the oldest sample leaves at the top bit
      always_ff @(posedge clk) begin
        if (rst) ff <= '0;
        else     ff <= {ff[STAGES-2:0], d};
      end

      assign q = ff[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/latch_sr_sync.sv
// rtl/latch_sr_sync.sv - clocked reset-dominant set/reset storage for magnetron enable
module latch_sr_sync
  import latch_sr_sync_pkg::*;
#(
  parameter int   SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter logic RESET_VALUE = Q_OFF
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q,
  output logic q_n,
  output logic invalid
);

  logic s_i;
  logic r_i;
  logic q_reg;
  logic invalid_reg;
  logic q_next;
  logic invalid_next;

  sync_ff_chain #(.STAGES(SYNC_STAGES)) u_sync_s (
    .clk (clk),
    .rst (rst),
    .d   (s),
    .q   (s_i)
  );

  sync_ff_chain #(.STAGES(SYNC_STAGES)) u_sync_r (
    .clk (clk),
    .rst (rst),
    .d   (r),
    .q   (r_i)
  );

  // Next state: set, clear or hold; a conflicting request forces the magnetron off and flags it
  always_comb begin
    q_next       = q_reg;
    invalid_next = 1'b0;
    case ({s_i, r_i})
      2'b10:   q_next = Q_ON;
      2'b01:   q_next = Q_OFF;
      2'b11: begin
        q_next       = Q_OFF;
        invalid_next = 1'b1;
      end
      default: q_next = q_reg;
    endcase
  end

  // Output registers; reset overrides any pending request
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg       <= RESET_VALUE;
      invalid_reg <= 1'b0;
    end else begin
      q_reg       <= q_next;
      invalid_reg <= invalid_next;
    end
  end

  // Outputs come only from registers so s and r never reach them combinationally
  assign q       = q_reg;
  assign q_n     = ~q_reg;
  assign invalid = invalid_reg;

endmodule

// File: tb/tb_latch_sr_sync.sv
// tb/tb_latch_sr_sync.sv - directed self-checking bench for latch_sr_sync at 0 and 2 sync stages
module tb_latch_sr_sync;

  logic clk;
  logic rst;
  logic s;
  logic r;
  logic q0, q_n0, inv0;
  logic q2, q_n2, inv2;

  int total;
  int bad;

  typedef struct packed {
    logic r;
    logic s;
    logic exp_q;
    logic exp_inv;
  } vec_t;

  vec_t tbl [8];

  latch_sr_sync #(.SYNC_STAGES(0), .RESET_VALUE(1'b0)) dut0 (
    .clk     (clk),
    .rst     (rst),
    .s       (s),
    .r       (r),
    .q       (q0),
    .q_n     (q_n0),
    .invalid (inv0)
  );

  latch_sr_sync #(.SYNC_STAGES(2), .RESET_VALUE(1'b0)) dut2 (
    .clk     (clk),
    .rst     (rst),
    .s       (s),
    .r       (r),
    .q       (q2),
    .q_n     (q_n2),
    .invalid (inv2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk0(input string name, input logic eq, input logic einv);
    chk({name, " dut0.q"}, q0, eq);
    chk({name, " dut0.q_n"}, q_n0, ~eq);
    chk({name, " dut0.invalid"}, inv0, einv);
  endtask

  task automatic chk2(input string name, input logic eq, input logic einv);
    chk({name, " dut2.q"}, q2, eq);
    chk({name, " dut2.q_n"}, q_n2, ~eq);
    chk({name, " dut2.invalid"}, inv2, einv);
  endtask

  task automatic idle(input int n);
    s = 1'b0;
    r = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [1:0] hist;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    s     = 1'b1;
    r     = 1'b0;

    tbl[0] = '{r: 1'b0, s: 1'b0, exp_q: 1'b0, exp_inv: 1'b0};
    tbl[1] = '{r: 1'b0, s: 1'b1, exp_q: 1'b1, exp_inv: 1'b0};
    tbl[2] = '{r: 1'b1, s: 1'b0, exp_q: 1'b0, exp_inv: 1'b0};
    tbl[3] = '{r: 1'b1, s: 1'b1, exp_q: 1'b0, exp_inv: 1'b1};
    tbl[4] = '{r: 1'b0, s: 1'b0, exp_q: 1'b0, exp_inv: 1'b0};
    tbl[5] = '{r: 1'b0, s: 1'b1, exp_q: 1'b1, exp_inv: 1'b0};
    tbl[6] = '{r: 1'b1, s: 1'b0, exp_q: 1'b0, exp_inv: 1'b0};
    tbl[7] = '{r: 1'b1, s: 1'b1, exp_q: 1'b0, exp_inv: 1'b1};

    // 1: reset wins over a held set request
    for (int i = 0; i < 2; i++) begin
      tick();
      chk0("reset", 1'b0, 1'b0);
      chk2("reset", 1'b0, 1'b0);
    end
    rst = 1'b0;
    s   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk0("post_reset_idle", 1'b0, 1'b0);
      chk2("post_reset_idle", 1'b0, 1'b0);
    end

    // 2: truth-table walk; dut2 must reproduce dut0's q two edges later
    hist = 2'b00;
    for (int k = 0; k < 8; k++) begin
      r = tbl[k].r;
      s = tbl[k].s;
      tick();
      chk0($sformatf("table[%0d]", k), tbl[k].exp_q, tbl[k].exp_inv);
      chk($sformatf("table_delayed[%0d] dut2.q", k), q2, hist[1]);
      hist = {hist[0], tbl[k].exp_q};
    end
    idle(4);
    chk2("table_flush", 1'b0, 1'b0);

    // 3: single set pulse then a long hold
    s = 1'b1;
    r = 1'b0;
    tick();
    chk0("set_pulse", 1'b1, 1'b0);
    s = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk0($sformatf("hold[%0d]", i), 1'b1, 1'b0);
    end
    chk2("hold_end", 1'b1, 1'b0);

    // 4: latency through two synchroniser stages
    r = 1'b1;
    tick();
    idle(4);
    chk2("latency_pre", 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      s = (k == 1);
      r = 1'b0;
      tick();
      chk2($sformatf("latency_set[%0d]", k), (k >= 3), 1'b0);
    end
    for (int k = 1; k <= 5; k++) begin
      s = 1'b0;
      r = (k == 1);
      tick();
      chk2($sformatf("latency_clr[%0d]", k), (k < 3), 1'b0);
    end

    // 5: reset mid-operation with set held, then release
    s = 1'b1;
    r = 1'b0;
    tick();
    idle(3);
    chk0("mid_pre", 1'b1, 1'b0);
    chk2("mid_pre", 1'b1, 1'b0);
    rst = 1'b1;
    s   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk0($sformatf("mid_rst[%0d]", k), 1'b0, 1'b0);
      chk2($sformatf("mid_rst[%0d]", k), 1'b0, 1'b0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk0($sformatf("mid_release[%0d]", k), 1'b1, 1'b0);
      chk2($sformatf("mid_release[%0d]", k), (k >= 3), 1'b0);
    end

    // 6: conflict while set forces off and flags exactly one cycle
    idle(3);
    chk0("conflict_pre", 1'b1, 1'b0);
    chk2("conflict_pre", 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      s = (k == 1);
      r = (k == 1);
      tick();
      chk0($sformatf("conflict[%0d]", k), 1'b0, (k == 1));
      chk2($sformatf("conflict[%0d]", k), (k < 3), (k == 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
